// File: rtl/switch_serial_adder_pkg.sv
// Shared mode and state encodings for the bit-serial switch adder.
`timescale 1ns/1ps
package switch_serial_adder_pkg;

  // Operation selected on the mode switches when start is pressed
  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  // Control FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_e;

endpackage

// File: rtl/serial_bit_adder.sv
// One-bit full adder with a registered carry; the carry flop is preloaded
// with the carry-in when a new operation is accepted.
`timescale 1ns/1ps
module serial_bit_adder (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_cin,
  input  logic i_en,
  input  logic i_x,
  input  logic i_y,
  output logic o_sum_c,
  output logic o_cout_c
);

  logic r_carry;

  assign o_sum_c  = i_x ^ i_y ^ r_carry;
  assign o_cout_c = (i_x & i_y) | (r_carry & (i_x ^ i_y));

  // Carry flop: preload on accept, advance once per computed bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_carry <= 1'b0;
    end else if (i_load) begin
      r_carry <= i_cin;
    end else if (i_en) begin
      r_carry <= o_cout_c;
    end
  end

endmodule

// File: rtl/switch_serial_adder.sv
// Bit-serial add/sub/accumulate/clear unit between the switch bank and LEDs.
// Operands are latched on an accepted start and summed LSB first, one bit
// per clock; the x register doubles as the sum shift register.
`timescale 1ns/1ps
module switch_serial_adder
  import switch_serial_adder_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [1:0]     i_mode,
  input  logic [2*W-1:0] i_switch,
  output logic [W:0]     o_led,
  output logic           o_busy,
  output logic           o_done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e        r_state;
  state_e        w_state_next;
  mode_e         r_mode;
  mode_e         w_mode_in;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_x;
  logic [W-1:0]  r_y;
  logic [W-1:0]  r_acc;
  logic [W:0]    r_led;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic [W-1:0]  w_sum_full;
  logic          w_accept;
  logic          w_clear;
  logic          w_last;
  logic          w_calc;
  logic          w_cin;
  logic          w_sum_bit;
  logic          w_cout;

  assign w_a        = i_switch[2*W-1:W];
  assign w_b        = i_switch[W-1:0];
  assign w_mode_in  = mode_e'(i_mode);
  assign w_calc     = (r_state == ST_CALC);
  assign w_cin      = (w_mode_in == MODE_SUB);
  // Final bit joins the W-1 bits already shifted into the top of r_x
  assign w_sum_full = {w_sum_bit, r_x[W-1:1]};

  assign o_led  = r_led;
  assign o_busy = r_busy;
  assign o_done = r_done;

  serial_bit_adder u_bit (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (w_accept),
    .i_cin    (w_cin),
    .i_en     (w_calc),
    .i_x      (r_x[0]),
    .i_y      (r_y[0]),
    .o_sum_c  (w_sum_bit),
    .o_cout_c (w_cout)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (w_mode_in == MODE_CLR) begin
            w_clear = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_state_next = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (r_cnt == CW'(W - 1)) begin
          w_last       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch, serial shifting, accumulator and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= MODE_ADD;
      r_cnt  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_acc  <= '0;
      r_led  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_next == ST_CALC);

      if (w_accept) begin
        r_mode <= w_mode_in;
        r_cnt  <= '0;
        r_x    <= (w_mode_in == MODE_ACC) ? r_acc : w_a;
        r_y    <= (w_mode_in == MODE_SUB) ? ~w_b : w_b;
      end

      if (w_calc) begin
        r_cnt <= r_cnt + CW'(1);
        r_x   <= w_sum_full;
        r_y   <= {1'b0, r_y[W-1:1]};
      end

      if (w_last) begin
        r_led  <= {w_cout, w_sum_full};
        r_done <= 1'b1;
        if (r_mode == MODE_ACC) begin
          r_acc <= w_sum_full;
        end
      end

      if (w_clear) begin
        r_acc  <= '0;
        r_led  <= '0;
        r_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/switch_serial_adder.md
# switch_serial_adder

Parametrised, sequential successor to the switch-to-LED nibble adder used in the lab boards. It latches two W-bit operands from the switch bank on a start strobe and adds them bit-serially, one bit per clock, LSB first. It supports add, subtract, accumulate and clear modes and drives a (W+1)-bit LED result with a busy/done handshake. It sits between the debounced switch bank / push-button strobe and the LED driver.

## Interface
- W, default 4: operand width in bits; legal range 2..16.
- clk  in  1  system clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- mode  in  2  operation: 00 add, 01 sub, 10 accumulate, 11 clear.
- switch  in  2W  operands: a = switch[2W-1:W], b = switch[W-1:0].
- led  out  W+1  result: {carry, sum[W-1:0]}.
- busy  out  1  high while a serial calculation is in progress.
- done  out  1  one-cycle pulse when led has been updated.

## Operation
- Reset: all outputs, accumulator and shift registers cleared (led=0, busy=0, done=0, acc=0); FSM returns to IDLE.
- Reset mid-operation aborts the calculation; no done pulse follows.
- FSM states:
  - IDLE: waits for start.
  - CALC: bit counter runs 0..W-1.
- IDLE to CALC on start with mode != 11. CALC to IDLE after bit W-1.
- On an accepted start, latch mode, the x operand and the y operand. Switch and mode changes after that edge are ignored.
- Operand and carry-in setup by mode:
  - add: x = a, y = b, carry-in 0.
  - sub: x = a, y = ~b, carry-in 1 (two's complement). led[W] = 1 means a >= b (no borrow).
  - accumulate: x = acc, y = b, carry-in 0. At completion acc <= sum[W-1:0]; the carry is reported in led[W] but not kept in acc.
- Clear (mode 11) never enters CALC. At the start edge: acc <= 0, led <= 0, done pulses the following cycle, busy stays 0.
- start while busy=1 is ignored: not queued, no error.
- Bit i of the sum is computed in CALC cycle i from x[i], y[i] and the registered carry. The final carry goes to led[W].
- led holds its value until the next completion, clear, or reset.

## Timing
- Define E0 as the edge that samples start=1 with busy=0.
- busy=1 from after E0 through the cycle following edge E(W-1).
- At edge EW:
  - led loads {carry, sum};
  - acc updates (accumulate mode only);
  - busy drops to 0;
  - done=1 for exactly one cycle.
- Latency: result valid W cycles after E0. Throughput is one operation per W+1 cycles at most.
- A start in the done cycle is accepted, since busy=0.
- Clear: done=1 and led=0 in the cycle after E0 (latency 1).
- rst and start on the same edge: rst wins.

## Structure
- Package switch_serial_adder_pkg holds:
  - mode constants MODE_ADD, MODE_SUB, MODE_ACC, MODE_CLR;
  - state encoding ST_IDLE, ST_CALC.
- Sub-module serial_bit_adder: one-bit full adder plus the carry flop, with synchronous load of carry-in. Instantiated once.
- Top level contains the FSM, bit counter ($clog2(W) bits), operand shift registers, accumulator and output registers.

## Test plan
All cases use W=4 unless stated.
- add, switch=8'h25, start pulse: led=5'h07, done exactly 4 cycles after E0, busy high for 4 cycles.
- add, switch=8'hAB: led=5'h15. Then sub, switch=8'h6C: led=5'h0A (6-12 = -6, no-borrow bit 0). Then sub, switch=8'hC6: led=5'h16.
- clear, then accumulate with switch=8'h09 twice:
  - after clear: led=0, done after 1 cycle;
  - first accumulate: led=5'h09;
  - second accumulate: led=5'h12, acc=4'h2.
- Start pulses during busy, and switch toggled during CALC: result unaffected, only one done pulse.
- rst asserted in CALC cycle 2: next cycle led=0, busy=0, done=0, no done pulse. A following add with 8'h25 gives 5'h07.
- W=8, add, switch=16'hFF01: led=9'h100, done 8 cycles after E0.
